seq_div8x4: RTL and testbench

Sequential restoring divider: an 8-bit dividend divided by a 4-bit divisor gives an 8-bit quotient and a 4-bit remainder. It is the inverse-direction companion to the 4x4 combinational multiplier, so any 8-bit product P = A*B can be decomposed back into A (quotient) and 0 (remainder) by dividing by B. It produces one quotient bit per clock and uses a start/busy/done handshake. It sits beside the multiplier in the arithmetic datapath of the term-project CPU.

---
 rtl/seq_div_pkg.sv | 27 ++
 rtl/seq_div8x4_div_step.sv | 27 ++
 rtl/seq_div8x4.sv | 150 +++++++++++++++
 tb/tb_seq_div8x4.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared widths, FSM encoding and constants for the sequential 8/4 divider.
package seq_div_pkg;

    localparam int unsigned DVD_W = 8;
    localparam int unsigned DVS_W = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned ST_W  = 2;

    // FSM state encoding
    localparam logic [ST_W-1:0] IDLE = 2'd0;
    localparam logic [ST_W-1:0] RUN  = 2'd1;
    localparam logic [ST_W-1:0] FIN  = 2'd2;

    // First iteration index; counts down to 0
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(DVD_W - 1);

    // Quotient reported when the divisor is zero
    localparam logic [DVD_W-1:0] DBZ_QUOTIENT = 8'hFF;

    // Result payload held on the outputs
    typedef struct packed {
        logic [DVD_W-1:0] quotient;
        logic [DVS_W-1:0] remainder;
        logic             div_by_zero;
    } div_result_t;

endpackage

// File: rtl/seq_div8x4_div_step.sv
// One restoring-division iteration (purely combinational).
//   partial      : current partial remainder (always < divisor)
//   dividend_msb : next dividend bit shifted into the trial value
//   divisor      : divisor
//   next_partial : partial remainder after the trial subtraction
//   q_bit        : quotient bit produced by this iteration
module div_step
    import seq_div_pkg::*;
(
    input  logic [DVS_W-1:0] partial,
    input  logic             dividend_msb,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W-1:0] next_partial,
    output logic             q_bit
);

    logic [DVS_W:0] trial;

    // The 5th bit only matters for the compare: since partial < divisor,
    // trial < 2*divisor and the difference always fits back in 4 bits.
    always_comb begin
        trial        = {partial, dividend_msb};
        q_bit        = (trial >= {1'b0, divisor});
        next_partial = q_bit ? DVS_W'(trial - {1'b0, divisor}) : trial[DVS_W-1:0];
    end

endmodule

// File: rtl/seq_div8x4.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient
// bit per clock, start/busy/done handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request; accepted only while busy=0
//   dividend    : 8-bit unsigned dividend, captured on accept
//   divisor     : 4-bit unsigned divisor, captured on accept
//   busy        : operation in progress
//   done        : one-cycle pulse when results update
//   quotient    : registered 8-bit quotient
//   remainder   : registered 4-bit remainder
//   div_by_zero : registered flag, captured divisor was zero
module seq_div8x4
    import seq_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [DVD_W-1:0] dvd_q,   dvd_d;
    logic [DVD_W-1:0] quo_q,   quo_d;
    logic [DVS_W-1:0] dvs_q,   dvs_d;
    logic [DVS_W-1:0] part_q,  part_d;
    logic             dbz_q,   dbz_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    div_result_t      res_q,   res_d;

    logic [DVS_W-1:0] step_partial;
    logic             step_qbit;

    div_step u_step (
        .partial      (part_q),
        .dividend_msb (dvd_q[DVD_W-1]),
        .divisor      (dvs_q),
        .next_partial (step_partial),
        .q_bit        (step_qbit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dvd_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            part_q <= '0;
            dbz_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            part_q <= part_d;
            dbz_q  <= dbz_d;
            busy_q <= busy_d;
            done_q <= done_d;
            res_q  <= res_d;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        part_d  = part_q;
        dbz_d   = dbz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d  = dividend;
                    dvs_d  = divisor;
                    cnt_d  = CNT_FIRST;
                    busy_d = 1'b1;
                    if (divisor == '0) begin
                        // Preload the divide-by-zero result; FIN publishes it.
                        quo_d   = DBZ_QUOTIENT;
                        part_d  = dividend[DVS_W-1:0];
                        dbz_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        quo_d   = '0;
                        part_d  = '0;
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                part_d = step_partial;
                quo_d  = {quo_q[DVD_W-2:0], step_qbit};
                dvd_d  = {dvd_q[DVD_W-2:0], 1'b0};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FIN;
                end
            end

            FIN: begin
                res_d.quotient    = quo_q;
                res_d.remainder   = part_q;
                res_d.div_by_zero = dbz_q;
                done_d            = 1'b1;
                busy_d            = 1'b0;
                state_d           = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = res_q.quotient;
    assign remainder   = res_q.remainder;
    assign div_by_zero = res_q.div_by_zero;

endmodule

// File: tb/tb_seq_div8x4.sv
// Scoreboard bench for seq_div8x4: the driver queues expected results as
// requests are accepted; a monitor checks them whenever done pulses.
module tb_seq_div8x4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'd0;
    logic [3:0] divisor = 4'd0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    seq_div8x4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive a request in the current (non-active) half cycle; accepted at next edge.
    task automatic issue_now(input logic [7:0] a, input logic [3:0] b,
                             input logic [7:0] eq, input logic [3:0] er,
                             input logic ez, input bit track);
        exp_t e;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        if (track) begin
            e.q   = eq;
            e.r   = er;
            e.z   = ez;
            e.due = cyc + ((b == 4'd0) ? 1 : 9);
            sb.push_back(e);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic ez);
        @(negedge clk);
        issue_now(a, b, eq, er, ez, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d results pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        bit   chk_low;
        exp_t e;
        chk_low = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_low) begin
                chk("done_one_cycle", 32'(done), 32'd0);
                chk_low = 1'b0;
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no result (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("quotient",    32'(quotient),    32'(e.q));
                    chk("remainder",   32'(remainder),   32'(e.r));
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
                    chk("busy_at_done", 32'(busy), 32'd0);
                    chk("latency_cycle", 32'(cyc), 32'(e.due));
                    chk_low = 1'b1;
                end
            end
        end
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_done",        32'(done),        32'd0);
        chk("rst_quotient",    32'(quotient),    32'd0);
        chk("rst_remainder",   32'(remainder),   32'd0);
        chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed divides
        issue(8'd225, 4'd15, 8'd15,  4'd0, 1'b0); drain();
        issue(8'd200, 4'd7,  8'd28,  4'd4, 1'b0); drain();
        issue(8'd255, 4'd1,  8'd255, 4'd0, 1'b0); drain();
        issue(8'd5,   4'd9,  8'd0,   4'd5, 1'b0); drain();

        // Divide by zero, then a normal divide clears the flag
        issue(8'h5A, 4'd0, 8'hFF, 4'hA, 1'b1); drain();
        issue(8'd60, 4'd6, 8'd10, 4'd0, 1'b0); drain();

        // Start and input changes during RUN are ignored
        issue(8'd100, 4'd3, 8'd33, 4'd1, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 4'd5;
        @(negedge clk);
        start = 1'b0; dividend = 8'hFF; divisor = 4'd1;
        wait_done();
        // Start raised in the done cycle is accepted
        issue_now(8'd50, 4'd5, 8'd10, 4'd0, 1'b0, 1'b1);
        drain();

        // Reset mid-operation abandons the divide
        @(negedge clk);
        issue_now(8'd200, 4'd7, 8'd0, 4'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",        32'(busy),        32'd0);
        chk("midrst_done",        32'(done),        32'd0);
        chk("midrst_quotient",    32'(quotient),    32'd0);
        chk("midrst_remainder",   32'(remainder),   32'd0);
        chk("midrst_div_by_zero", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0); drain();

        // Inverse of the 4x4 multiplier: (A*B)/B == A remainder 0
        for (int a = 1; a <= 15; a++) begin
            for (int b = 1; b <= 15; b++) begin
                issue(8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0);
                drain();
            end
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
